offnariscv_kanata_tracer: RTL and testbench

//  Cycle-accurate pipeline event recorder for Kanata trace generation in simulation benches.
//  - Snoops instruction fetch, NUM_STAGES handshake points and the retire/flush port.
//  - Packs every cycle with at least one event into a record and buffers it in a FIFO.
//  - The bench drains the FIFO over a valid/ready port, so DPI readers need not sample every cycle.
//  - Sits beside offnariscv_core in the core test wrapper. Not synthesised into silicon.

---
 rtl/offnariscv_pkg.sv | 25 ++
 rtl/offnariscv_sync_fifo.sv | 63 ++++++
 rtl/offnariscv_kanata_tracer.sv | 95 +++++++++
 tb/tb_offnariscv_kanata_tracer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/offnariscv_pkg.sv
// Shared offnariscv types: instruction id width and the Kanata trace record.
package offnariscv_pkg;

  localparam int INST_ID_WIDTH = 8;

  // Record for the default tracer parameters; rsvd pads to kanata_rec_w() and is always 0.
  typedef struct packed {
    logic                                rsvd;
    logic [15:0]                         delta;
    logic                                lost;
    logic                                fetch_v;
    logic [INST_ID_WIDTH-1:0]            fetch_id;
    logic [3:0]                          stage_v;
    logic [3:0][INST_ID_WIDTH-1:0]       stage_id;
    logic [31:0]                         inst;
    logic                                retire_v;
    logic [INST_ID_WIDTH-1:0]            retire_id;
    logic                                retire_flush;
  } kanata_rec_t;

  function automatic int kanata_rec_w(input int ns, input int idw, input int iw, input int dw);
    return dw + 2 + ns*(idw+1) + iw + 2*idw + 3;
  endfunction

endpackage

// File: rtl/offnariscv_sync_fifo.sv
// Synchronous FIFO, registered pointers/count; FWFT or registered-read output.
module offnariscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter bit FWFT  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_wr, w_rd;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign w_rd    = i_rd_en & ~o_empty;
  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign w_wr    = i_wr_en & (~o_full | w_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_rdata = o_empty ? '0 : r_mem[r_rptr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_dout <= '0;
        else if (w_rd) r_dout <= r_mem[r_rptr];
      end
      assign o_rdata = r_dout;
    end
  endgenerate

endmodule

// File: rtl/offnariscv_kanata_tracer.sv
// Kanata pipeline event recorder: packs event cycles into records and queues them for the bench.
module offnariscv_kanata_tracer
  import offnariscv_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int ID_WIDTH    = INST_ID_WIDTH,
  parameter int INST_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int DELTA_WIDTH = 16,
  localparam int REC_W      = kanata_rec_w(NUM_STAGES, ID_WIDTH, INST_WIDTH, DELTA_WIDTH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic                           i_fetch_valid,
  input  logic [ID_WIDTH-1:0]            i_fetch_id,
  input  logic [NUM_STAGES-1:0]          i_stage_ack,
  input  logic [NUM_STAGES*ID_WIDTH-1:0] i_stage_id,
  input  logic [INST_WIDTH-1:0]          i_dec_inst,
  input  logic                           i_retire_valid,
  input  logic [ID_WIDTH-1:0]            i_retire_id,
  input  logic                           i_retire_flush,
  output logic                           o_ev_valid,
  input  logic                           i_ev_ready,
  output logic [REC_W-1:0]               o_ev_data,
  output logic                           o_overflow,
  output logic [15:0]                    o_drop_cnt
);

  logic [DELTA_WIDTH-1:0]              r_dcnt;
  logic                                r_lost;
  logic                                r_overflow;
  logic [15:0]                         r_drop_cnt;
  logic                                w_event, w_pop, w_push, w_drop, w_full, w_empty;
  logic [NUM_STAGES-1:0][ID_WIDTH-1:0] w_stage_id;
  logic [REC_W-1:0]                    w_rec;

  assign w_event = i_en & (i_fetch_valid | (|i_stage_ack) | i_retire_valid);
  assign w_pop   = o_ev_valid & i_ev_ready;
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & w_full & ~w_pop;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    assign w_stage_id[s] = i_stage_ack[s] ? i_stage_id[s*ID_WIDTH +: ID_WIDTH] : '0;
  end

  // Top bit is a reserved zero pad so the record width matches kanata_rec_w().
  always_comb begin
    w_rec = '0;
    w_rec[REC_W-2:0] = {
      r_dcnt, r_lost,
      i_fetch_valid, (i_fetch_valid ? i_fetch_id : ID_WIDTH'(0)),
      i_stage_ack, w_stage_id,
      (i_stage_ack[0] ? i_dec_inst : INST_WIDTH'(0)),
      i_retire_valid, (i_retire_valid ? i_retire_id : ID_WIDTH'(0)),
      (i_retire_valid & i_retire_flush)
    };
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dcnt     <= '0;
      r_lost     <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_event)             r_dcnt <= DELTA_WIDTH'(1);
      else if (r_dcnt != '1)   r_dcnt <= r_dcnt + 1'b1;
      if (w_push)              r_lost <= 1'b0;
      else if (w_drop)         r_lost <= 1'b1;
      if (w_drop)              r_overflow <= 1'b1;
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  offnariscv_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH),
    .FWFT  (1'b1)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr_en (w_push),
    .i_wdata (w_rec),
    .i_rd_en (w_pop),
    .o_rdata (o_ev_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_ev_valid = ~w_empty;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_offnariscv_kanata_tracer.sv
// Scoreboard bench for the Kanata tracer: directed events, monitor checks drained records in order.
module tb_offnariscv_kanata_tracer;
  import offnariscv_pkg::*;

  localparam int NS = 4, IDW = 8, IW = 32, DW = 16, DEPTH = 16;
  localparam int REC_W = kanata_rec_w(NS, IDW, IW, DW);

  logic              clk = 1'b0, rst_n, en;
  logic              fetch_valid, retire_valid, retire_flush, ev_valid, ev_ready, overflow;
  logic [IDW-1:0]    fetch_id, retire_id;
  logic [NS-1:0]     stage_ack;
  logic [NS*IDW-1:0] stage_id;
  logic [IW-1:0]     dec_inst;
  logic [REC_W-1:0]  ev_data;
  logic [15:0]       drop_cnt;

  kanata_rec_t sb[$];
  kanata_rec_t mon_exp;
  int n_cmp = 0, n_err = 0;

  offnariscv_kanata_tracer #(
    .NUM_STAGES(NS), .ID_WIDTH(IDW), .INST_WIDTH(IW), .DEPTH(DEPTH), .DELTA_WIDTH(DW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_fetch_valid(fetch_valid), .i_fetch_id(fetch_id),
    .i_stage_ack(stage_ack), .i_stage_id(stage_id), .i_dec_inst(dec_inst),
    .i_retire_valid(retire_valid), .i_retire_id(retire_id), .i_retire_flush(retire_flush),
    .o_ev_valid(ev_valid), .i_ev_ready(ev_ready), .o_ev_data(ev_data),
    .o_overflow(overflow), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  function automatic kanata_rec_t mk(input logic [15:0] d, input logic lost, input logic fv,
                                     input logic [7:0] fid, input logic [3:0] sv,
                                     input logic [31:0] sids, input logic [31:0] inst,
                                     input logic rv, input logic [7:0] rid, input logic rfl);
    kanata_rec_t r;
    r = '0;
    r.delta = d; r.lost = lost; r.fetch_v = fv; r.fetch_id = fid;
    r.stage_v = sv; r.stage_id = sids; r.inst = inst;
    r.retire_v = rv; r.retire_id = rid; r.retire_flush = rfl;
    return r;
  endfunction

  task automatic idle_in();
    fetch_valid = 0; fetch_id = 0; stage_ack = 0; stage_id = 0; dec_inst = 0;
    retire_valid = 0; retire_id = 0; retire_flush = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted record must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_record act=%h req=none", ev_data);
      end else begin
        mon_exp = sb.pop_front();
        chk("record", 128'(ev_data), 128'(mon_exp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; ev_ready = 1'b1; idle_in();
    #12;
    chk("rst_valid", 128'(ev_valid), 128'(0));
    chk("rst_data", 128'(ev_data), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    tick(2);
    rst_n = 1'b1;
    tick(5);

    // Fetch after 5 idle cycles; record must not bypass the empty FIFO.
    fetch_valid = 1; fetch_id = 8'd3;
    sb.push_back(mk(16'd5, 0, 1, 8'd3, 4'b0000, 32'h0, 32'h0, 0, 8'h0, 0));
    @(negedge clk);
    chk("no_bypass", 128'(ev_valid), 128'(0));
    tick(1);
    idle_in();
    stage_ack = 4'b0101; stage_id = 32'hAA09_AA07; dec_inst = 32'h00a00093;
    sb.push_back(mk(16'd1, 0, 0, 8'h0, 4'b0101, 32'h0009_0007, 32'h00a00093, 0, 8'h0, 0));
    @(negedge clk);
    chk("valid_next_cycle", 128'(ev_valid), 128'(1));
    tick(1);
    idle_in();
    tick(3);

    // Overflow: 18 events with no drain, 16 kept.
    ev_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      fetch_valid = 1; fetch_id = 8'(10 + i);
      if (i < 16) sb.push_back(mk((i == 0) ? 16'd4 : 16'd1, 0, 1, 8'(10 + i), 4'b0, 32'h0, 32'h0, 0, 8'h0, 0));
      tick(1);
    end
    idle_in();
    @(negedge clk);
    chk("drop_cnt_2", 128'(drop_cnt), 128'(2));
    chk("overflow_set", 128'(overflow), 128'(1));
    chk("full_valid", 128'(ev_valid), 128'(1));
    chk("hold_stable", 128'(ev_data), 128'(sb[0]));
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_stable2", 128'(ev_data), 128'(sb[0]));
    @(posedge clk); #1;
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    fetch_valid = 1; fetch_id = 8'd40;
    sb.push_back(mk(16'd4, 1, 1, 8'd40, 4'b0, 32'h0, 32'h0, 0, 8'h0, 0));
    tick(1);
    // Full FIFO, push and pop together: accepted, no drop.
    ev_ready = 1'b1; fetch_id = 8'd41;
    sb.push_back(mk(16'd1, 0, 1, 8'd41, 4'b0, 32'h0, 32'h0, 0, 8'h0, 0));
    tick(1);
    ev_ready = 1'b0; fetch_id = 8'd42;
    tick(1);
    idle_in();
    @(negedge clk);
    chk("pushpop_no_drop_then_full", 128'(drop_cnt), 128'(3));
    chk("overflow_sticky", 128'(overflow), 128'(1));
    @(posedge clk); #1;
    ev_ready = 1'b1;
    tick(20);
    fetch_valid = 1; fetch_id = 8'd43;
    sb.push_back(mk(16'd22, 1, 1, 8'd43, 4'b0, 32'h0, 32'h0, 0, 8'h0, 0));
    tick(1);
    fetch_id = 8'd44;
    sb.push_back(mk(16'd1, 0, 1, 8'd44, 4'b0, 32'h0, 32'h0, 0, 8'h0, 0));
    tick(1);
    idle_in();
    tick(3);
    chk("drained_1", 128'(sb.size()), 128'(0));

    // Reset mid-drain with three records queued.
    ev_ready = 1'b0;
    retire_valid = 1; retire_id = 8'd5; retire_flush = 1;
    sb.push_back(mk(16'd4, 0, 0, 8'h0, 4'b0, 32'h0, 32'h0, 1, 8'd5, 1));
    tick(1);
    idle_in();
    fetch_valid = 1; fetch_id = 8'd60;
    sb.push_back(mk(16'd1, 0, 1, 8'd60, 4'b0, 32'h0, 32'h0, 0, 8'h0, 0));
    tick(1);
    idle_in();
    stage_ack = 4'b1000; stage_id = 32'h3D55_5555; dec_inst = 32'hdeadbeef;
    sb.push_back(mk(16'd1, 0, 0, 8'h0, 4'b1000, 32'h3D00_0000, 32'h0, 0, 8'h0, 0));
    tick(1);
    idle_in();
    ev_ready = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 128'(ev_valid), 128'(0));
    chk("midreset_data", 128'(ev_data), 128'(0));
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 128'(ev_valid), 128'(0));
    chk("post_rst_drop_cnt", 128'(drop_cnt), 128'(0));
    chk("post_rst_overflow", 128'(overflow), 128'(0));
    @(posedge clk); #1;
    tick(1);
    fetch_valid = 1; fetch_id = 8'd50;
    sb.push_back(mk(16'd2, 0, 1, 8'd50, 4'b0, 32'h0, 32'h0, 0, 8'h0, 0));
    tick(1);
    idle_in();
    tick(3);

    // Capture disabled for a long stretch: no records, delta saturates.
    en = 1'b0; fetch_valid = 1; fetch_id = 8'd77; stage_ack = 4'b1111;
    tick(70000);
    @(negedge clk);
    chk("en0_no_record", 128'(ev_valid), 128'(0));
    chk("en0_no_drop", 128'(drop_cnt), 128'(0));
    @(posedge clk); #1;
    idle_in();
    en = 1'b1; fetch_valid = 1; fetch_id = 8'd78;
    sb.push_back(mk(16'hFFFF, 0, 1, 8'd78, 4'b0, 32'h0, 32'h0, 0, 8'h0, 0));
    tick(1);
    idle_in();
    tick(3);
    chk("drained_final", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
